// File: rtl/nios_system_sqrt_engine.sv
// Iterative restoring integer square root, one root bit per clock.
// Launched by a rising edge of start_i; result held until the next launch.
module nios_system_sqrt_engine #(
   parameter  int DATA_W = 32,
   localparam int RES_W  = DATA_W / 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] operand_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [RES_W-1:0]  root_o,
   output logic [RES_W:0]    rem_o
);

   localparam int CNT_W = (RES_W > 1) ? $clog2(RES_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_start_q;
   logic [DATA_W-1:0]  r_op;
   logic [RES_W-1:0]   r_root;
   logic [RES_W:0]     r_rem;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_launch;
   logic               w_last;
   logic               w_ge;
   logic [RES_W+1:0]   w_r;
   logic [RES_W+1:0]   w_t;
   logic [RES_W:0]     w_diff;

   assign w_launch = start_i & ~r_start_q;
   assign w_last   = (r_cnt == CNT_W'(RES_W - 1));
   assign w_r      = {r_rem[RES_W-1:0], r_op[DATA_W-1 -: 2]};
   assign w_t      = {r_root, 2'b01};
   assign w_ge     = (w_r >= w_t);
   // The true difference always fits in RES_W+1 bits, so the top bit can be dropped.
   assign w_diff   = w_r[RES_W:0] - w_t[RES_W:0];

   assign busy_o = (r_state == S_BUSY);
   assign done_o = (r_state == S_DONE);
   assign root_o = r_root;
   assign rem_o  = r_rem;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_launch) w_next = S_BUSY;
         S_BUSY: if (w_last)   w_next = S_DONE;
         S_DONE: if (!start_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Edge detector resets high so a start held across reset cannot launch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_q <= 1'b1;
         r_op      <= '0;
         r_root    <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
      end else begin
         r_start_q <= start_i;
         if (r_state == S_IDLE && w_launch) begin
            r_op   <= operand_i;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
         end else if (r_state == S_BUSY) begin
            r_op   <= r_op << 2;
            r_rem  <= w_ge ? w_diff : w_r[RES_W:0];
            r_root <= {r_root[RES_W-2:0], w_ge};
            r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_nios_system_sqrt_engine.sv
// Directed and random checks of the sqrt engine against a binary-search
// reference, with expected results queued at launch and popped at done.
module tb_nios_system_sqrt_engine;

   localparam int DW = 32;
   localparam int RW = DW / 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_i = 1'b0;
   logic [DW-1:0] operand_i = '0;
   logic          busy_o;
   logic          done_o;
   logic [RW-1:0] root_o;
   logic [RW:0]   rem_o;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [DW-1:0] op;
      logic [RW-1:0] root;
      logic [RW:0]   rem;
   } exp_t;

   exp_t sb[$];

   nios_system_sqrt_engine #(.DATA_W(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start_i   (start_i),
      .operand_i (operand_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .root_o    (root_o),
      .rem_o     (rem_o)
   );

   always #5 clk = ~clk;

   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned lo = 0;
      longint unsigned hi = 65535;
      longint unsigned mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= x) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] op);
      exp_t e;
      longint unsigned r;
      r = isqrt(64'(op));
      e.op   = op;
      e.root = r[RW-1:0];
      e.rem  = 17'(64'(op) - r * r);
      sb.push_back(e);
   endtask

   task automatic launch(input logic [DW-1:0] op);
      @(negedge clk);
      operand_i = op;
      start_i = 1'b1;
      push(op);
   endtask

   task automatic wait_done(output int bc);
      bc = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done_o) break;
         if (busy_o) bc++;
      end
   endtask

   task automatic check_result();
      exp_t e;
      longint unsigned r;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         r = 64'(root_o);
         chk("root", 64'(root_o), 64'(e.root));
         chk("rem", 64'(rem_o), 64'(e.rem));
         chk("prop_lo", 64'(r * r <= 64'(e.op)), 64'd1);
         chk("prop_hi", 64'(64'(e.op) < (r + 1) * (r + 1)), 64'd1);
         chk("prop_rem", 64'(rem_o), 64'(e.op) - r * r);
      end
   endtask

   task automatic run_op(input logic [DW-1:0] op);
      int bc;
      launch(op);
      wait_done(bc);
      chk("done", 64'(done_o), 64'd1);
      chk("latency", 64'(bc), 64'd16);
      check_result();
      start_i = 1'b0;
      @(negedge clk);
      chk("done_clear", 64'(done_o), 64'd0);
   endtask

   initial begin
      int bc;
      logic [DW-1:0] op;

      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_root", 64'(root_o), 64'd0);
      chk("rst_rem", 64'(rem_o), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(32'd16);
      chk("r16_root", 64'(root_o), 64'd4);
      chk("r16_rem", 64'(rem_o), 64'd0);
      run_op(32'd17);
      chk("r17_rem", 64'(rem_o), 64'd1);
      run_op(32'd0);
      run_op(32'd1);
      run_op(32'hFFFF_FFFF);
      chk("max_root", 64'(root_o), 64'hFFFF);
      chk("max_rem", 64'(rem_o), 64'h1FFFE);

      // start pulse and operand change while busy
      launch(32'd50);
      repeat (4) @(negedge clk);
      start_i = 1'b0;
      operand_i = 32'd99;
      @(negedge clk);
      start_i = 1'b1;
      wait_done(bc);
      chk("pulse_done", 64'(done_o), 64'd1);
      chk("pulse_busy_cnt", 64'(bc), 64'd11);
      check_result();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("done_hold", 64'(done_o), 64'd1);
         chk("hold_root", 64'(root_o), 64'd7);
      end
      start_i = 1'b0;
      @(negedge clk);
      chk("hold_clear", 64'(done_o), 64'd0);
      chk("idle_root", 64'(root_o), 64'd7);
      chk("idle_rem", 64'(rem_o), 64'd1);

      // start dropped while busy: done is a single-cycle pulse
      launch(32'd200);
      @(negedge clk);
      start_i = 1'b0;
      wait_done(bc);
      chk("dpulse_done", 64'(done_o), 64'd1);
      chk("dpulse_busy_cnt", 64'(bc), 64'd15);
      check_result();
      @(negedge clk);
      chk("dpulse_gone", 64'(done_o), 64'd0);
      chk("dpulse_busy", 64'(busy_o), 64'd0);

      // asynchronous reset mid-iteration with start held high
      @(negedge clk);
      operand_i = 32'd1000;
      start_i = 1'b1;
      repeat (9) @(negedge clk);
      chk("mid_busy", 64'(busy_o), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_done", 64'(done_o), 64'd0);
      chk("arst_root", 64'(root_o), 64'd0);
      chk("arst_rem", 64'(rem_o), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("nolaunch_busy", 64'(busy_o), 64'd0);
      chk("nolaunch_done", 64'(done_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      run_op(32'd1000);

      for (int i = 0; i < 2000; i++) begin
         op = $urandom;
         if (i % 4 == 1) op = op >> $urandom_range(31, 0);
         run_op(op);
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
